qspi_ctrl: RTL and testbench

QSPI_CTRL -- requirements
Module: qspi_ctrl

---
 rtl/qspi_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_qspi_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_ctrl.sv
// qspi_ctrl: quad-SPI master for a boot flash and two optional PSRAMs.
// Define QSPI_CTRL_RAM_EN to enable the RAM A / RAM B targets.
module qspi_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [1:0]  target,
  input  logic        write,
  input  logic [23:0] addr,
  input  logic [1:0]  len,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        qspi_clk,
  output logic [3:0]  qspi_data_out,
  output logic [3:0]  qspi_data_oe,
  input  logic [3:0]  qspi_data_in,
  output logic        qspi_flash_select,
  output logic        qspi_ram_a_select,
  output logic        qspi_ram_b_select
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    DONE
  } state_t;

  state_t state, state_d;

  logic        ph;
  logic [3:0]  cnt;
  logic [31:0] sh;
  logic [1:0]  tgt;
  logic [1:0]  ln;
  logic        wr;
  logic [23:0] adr;
  logic [31:0] wd;
  logic        err_q;

  logic        bad;
  logic        accept;
  logic        step;
  logic        drive;
  logic [2:0]  ni;
  logic [4:0]  pos;

`ifdef QSPI_CTRL_RAM_EN
  assign bad = (target == 2'd3) ||
               (target == 2'd0 && write);
`else
  assign bad = (target != 2'd0) || write;
`endif

  assign accept = start &&
                  (state == IDLE || state == DONE);
  assign busy = state inside {CMD, ADDR, MODE, DUMMY, DATA};
  assign done = (state == DONE);
  assign error = err_q;

  // cnt counts remaining SPI cycles of the current field
  assign step = busy && ph && (cnt == 4'd0);

  assign drive = (state inside {CMD, ADDR, MODE}) ||
                 (state == DATA && wr);

  assign qspi_clk = busy && ph;
  assign qspi_data_oe = drive ? 4'hF : 4'h0;
  assign qspi_data_out = drive ? sh[31:28] : 4'h0;

  assign qspi_flash_select = !(busy && tgt == 2'd0);
`ifdef QSPI_CTRL_RAM_EN
  assign qspi_ram_a_select = !(busy && tgt == 2'd1);
  assign qspi_ram_b_select = !(busy && tgt == 2'd2);
`else
  assign qspi_ram_a_select = 1'b1;
  assign qspi_ram_b_select = 1'b1;
`endif

  // nibble index within DATA -> little-endian bit slot
  assign ni = {ln, 1'b1} - cnt[2:0];
  assign pos = {ni[2:1], ~ni[0], 2'b00};

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept && !bad)
          state_d = (target == 2'd0) ? ADDR : CMD;
      end
      CMD:
        if (step) state_d = ADDR;
      ADDR:
        if (step) begin
          if (tgt == 2'd0) state_d = MODE;
          else if (wr) state_d = DATA;
          else state_d = DUMMY;
        end
      MODE:
        if (step) state_d = DUMMY;
      DUMMY:
        if (step) state_d = DATA;
      DATA:
        if (step) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph <= 1'b0;
      cnt <= 4'd0;
      sh <= 32'd0;
      tgt <= 2'd0;
      ln <= 2'd0;
      wr <= 1'b0;
      adr <= 24'd0;
      wd <= 32'd0;
      err_q <= 1'b0;
      rdata <= 32'd0;
    end else begin
      err_q <= accept && bad;
      if (accept && !bad) begin
        tgt <= target;
        ln <= len;
        wr <= write;
        adr <= addr;
        wd <= wdata;
        ph <= 1'b0;
        if (!write) rdata <= 32'd0;
        if (target == 2'd0) begin
          sh <= {addr, 8'h00};
          cnt <= 4'd5;
        end else begin
          sh <= {(write ? 8'h02 : 8'h0B), 24'h0};
          cnt <= 4'd1;
        end
      end else if (busy) begin
        ph <= ~ph;
        if (!ph) begin
          if (state == DATA && !wr)
            rdata[pos +: 4] <= qspi_data_in;
        end else if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
          sh <= {sh[27:0], 4'h0};
        end else begin
          unique case (state)
            CMD: begin
              sh <= {adr, 8'h00};
              cnt <= 4'd5;
            end
            ADDR:
              unique case (1'b1)
                tgt == 2'd0: begin
                  sh <= {8'hA5, 24'h0};
                  cnt <= 4'd1;
                end
                wr: begin
                  sh <= {wd[7:0], wd[15:8],
                         wd[23:16], wd[31:24]};
                  cnt <= {1'b0, ln, 1'b1};
                end
                default: cnt <= 4'd3;
              endcase
            MODE: cnt <= 4'd3;
            DUMMY: cnt <= {1'b0, ln, 1'b1};
            default: cnt <= 4'd0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_ctrl.sv
// tb_qspi_ctrl: randomized scoreboard bench for qspi_ctrl with
// behavioural flash / PSRAM device models on the quad bus.
module tb_qspi_ctrl;

`ifdef QSPI_CTRL_RAM_EN
  localparam bit RAM_EN = 1'b1;
`else
  localparam bit RAM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  target = 2'd0;
  logic        write = 1'b0;
  logic [23:0] addr = 24'd0;
  logic [1:0]  len = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        busy, done, error;
  logic        qspi_clk;
  logic [3:0]  qspi_data_out, qspi_data_oe;
  logic [3:0]  qspi_data_in;
  logic        qspi_flash_select;
  logic        qspi_ram_a_select;
  logic        qspi_ram_b_select;
  logic        sel_all;

  qspi_ctrl dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .target(target),
    .write(write),
    .addr(addr),
    .len(len),
    .wdata(wdata),
    .rdata(rdata),
    .busy(busy),
    .done(done),
    .error(error),
    .qspi_clk(qspi_clk),
    .qspi_data_out(qspi_data_out),
    .qspi_data_oe(qspi_data_oe),
    .qspi_data_in(qspi_data_in),
    .qspi_flash_select(qspi_flash_select),
    .qspi_ram_a_select(qspi_ram_a_select),
    .qspi_ram_b_select(qspi_ram_b_select)
  );

  always #5 clk = ~clk;

  assign sel_all = qspi_flash_select & qspi_ram_a_select &
                   qspi_ram_b_select;

  typedef struct {
    bit          is_err;
    logic [31:0] rd;
    int          cycles;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd = 32'd0;

  logic [7:0] ref_a [logic [23:0]];
  logic [7:0] ref_b [logic [23:0]];
  logic [7:0] dev_a [logic [23:0]];
  logic [7:0] dev_b [logic [23:0]];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    if (a >= 24'h10 && a <= 24'h13)
      return 8'h11 * (a[7:0] - 8'h0F);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_byte(input int k,
                                          input logic [23:0] a);
    if (k == 0) return rom_byte(a);
    if (k == 1) return ref_a.exists(a) ? ref_a[a] : 8'h00;
    return ref_b.exists(a) ? ref_b[a] : 8'h00;
  endfunction

  function automatic void ref_wr(input int k, input logic [23:0] a,
                                 input logic [7:0] v);
    if (k == 1) ref_a[a] = v;
    else ref_b[a] = v;
  endfunction

  function automatic logic [7:0] dev_byte(input int k,
                                          input logic [23:0] a);
    if (k == 0) return rom_byte(a);
    if (k == 1) return dev_a.exists(a) ? dev_a[a] : 8'h00;
    return dev_b.exists(a) ? dev_b[a] : 8'h00;
  endfunction

  // device side: decodes the quad bus, serves reads, stores writes
  int          dcyc = 0;
  logic [7:0]  dcmd;
  logic [23:0] dadr;
  logic [3:0]  dhi;
  initial begin
    int dk, d;
    bit drd;
    logic [3:0] nib, oe;
    logic [7:0] b;
    qspi_data_in = 4'h0;
    dcmd = 8'h00;
    dadr = 24'h0;
    dhi = 4'h0;
    forever begin
      @(posedge qspi_clk or negedge sel_all);
      #1;
      if (!qspi_clk) begin
        dcyc = 0;
        dcmd = 8'h00;
        dadr = 24'h0;
        qspi_data_in = 4'h0;
      end else if (!sel_all) begin
        nib = qspi_data_out;
        oe = qspi_data_oe;
        dk = !qspi_flash_select ? 0 : (!qspi_ram_a_select ? 1 : 2);
        drd = 1'b0;
        if (dk == 0) begin
          drd = 1'b1;
          if (dcyc < 6) begin
            dadr = {dadr[19:0], nib};
            chk("flash_addr_oe", 32'(oe), 32'hF);
          end else if (dcyc < 8) begin
            chk("flash_mode_nib", 32'(nib),
                (dcyc == 6) ? 32'hA : 32'h5);
            chk("flash_mode_oe", 32'(oe), 32'hF);
          end else begin
            chk("flash_rd_oe", 32'(oe), 32'h0);
          end
        end else begin
          if (dcyc < 2) begin
            dcmd = {dcmd[3:0], nib};
            chk("ram_cmd_oe", 32'(oe), 32'hF);
          end else if (dcyc < 8) begin
            dadr = {dadr[19:0], nib};
            chk("ram_addr_oe", 32'(oe), 32'hF);
          end else if (dcmd == 8'h0B) begin
            drd = 1'b1;
            chk("ram_rd_oe", 32'(oe), 32'h0);
          end else if (dcmd == 8'h02) begin
            chk("ram_wr_oe", 32'(oe), 32'hF);
            d = dcyc - 8;
            if (d % 2 == 0) dhi = nib;
            else if (dk == 1) dev_a[dadr + 24'(d / 2)] = {dhi, nib};
            else dev_b[dadr + 24'(d / 2)] = {dhi, nib};
          end else begin
            chk("ram_cmd", 32'(dcmd), 32'h0B);
          end
        end
        dcyc++;
        if (drd && dcyc >= 12) begin
          d = dcyc - 12;
          b = dev_byte(dk, dadr + 24'(d / 2));
          qspi_data_in = (d % 2 == 0) ? b[7:4] : b[3:0];
        end
      end
    end
  end

  // monitor: pops one expectation per done/error pulse
  int   cyc = 0;
  int   sel_start = 0;
  int   multi = 0;
  logic sel_prev = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      sel_prev = 1'b1;
    end else begin
      cyc++;
      if (!sel_all && sel_prev) sel_start = cyc;
      sel_prev = sel_all;
      if ($countones({qspi_flash_select, qspi_ram_a_select,
                      qspi_ram_b_select}) < 2)
        multi++;
      if (done || error) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 32'({done, error}), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("resp_kind", 32'({done, error}),
              e.is_err ? 32'd1 : 32'd2);
          if (e.is_err) begin
            chk("err_busy", 32'(busy), 32'd0);
            chk("err_sel", 32'({qspi_flash_select, qspi_ram_a_select,
                                qspi_ram_b_select}), 32'h7);
          end else begin
            chk("rdata", rdata, e.rd);
            chk("latency", 32'(cyc - sel_start), 32'(e.cycles));
            chk("done_busy", 32'({busy, qspi_clk}), 32'd0);
            chk("done_sel", 32'({qspi_flash_select, qspi_ram_a_select,
                                 qspi_ram_b_select}), 32'h7);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done || error) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400)
      chk("idle_timeout", 32'({busy, done, error}), 32'd0);
  endtask

  task automatic issue(input logic [1:0] tg, input logic wr,
                       input logic [23:0] a, input logic [1:0] l,
                       input logic [31:0] wd);
    exp_t e;
    logic [31:0] rd;
    bit bad;
    wait_idle();
    bad = (tg == 2'd3) || (tg == 2'd0 && wr) ||
          (!RAM_EN && tg != 2'd0);
    e.is_err = bad;
    e.rd = last_rd;
    e.cycles = 0;
    if (!bad && wr) begin
      for (int k = 0; k <= int'(l); k++)
        ref_wr(int'(tg), a + 24'(k), wd[8*k +: 8]);
      e.cycles = 2 * (8 + 2 * (int'(l) + 1));
    end else if (!bad) begin
      rd = 32'd0;
      for (int k = 0; k <= int'(l); k++)
        rd[8*k +: 8] = ref_byte(int'(tg), a + 24'(k));
      last_rd = rd;
      e.rd = rd;
      e.cycles = 2 * (12 + 2 * (int'(l) + 1));
    end
    sbq.push_back(e);
    target = tg;
    write = wr;
    addr = a;
    len = l;
    wdata = wd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    target = 2'($urandom);
    write = 1'($urandom);
    addr = 24'($urandom);
    len = 2'($urandom);
    wdata = $urandom;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, 32'({qspi_flash_select, qspi_ram_a_select,
                            qspi_ram_b_select}), 32'h7);
    chk({tag, "_sclk_busy"}, 32'({qspi_clk, busy, done, error}), 32'd0);
    chk({tag, "_bus"}, 32'({qspi_data_oe, qspi_data_out}), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    bit hit;
    logic [23:0] a;
    #3 rstn = 1'b0;
    #4;
    chk_reset("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    issue(2'd0, 1'b0, 24'h000010, 2'd3, 32'd0);
    issue(2'd1, 1'b1, 24'h000004, 2'd1, 32'h0000BEEF);
    issue(2'd1, 1'b0, 24'h000004, 2'd1, 32'd0);
    wait_idle();
`ifdef QSPI_CTRL_RAM_EN
    chk("ram_a_4", 32'(dev_byte(1, 24'h4)), 32'hEF);
    chk("ram_a_5", 32'(dev_byte(1, 24'h5)), 32'hBE);
`endif
    issue(2'd3, 1'b0, 24'h000020, 2'd0, 32'd0);
    issue(2'd0, 1'b1, 24'h000020, 2'd0, 32'h12345678);

    issue(2'd0, 1'b0, 24'h000100, 2'd3, 32'd0);
    for (int i = 0; i < 4; i++) begin
      target = 2'($urandom);
      write = 1'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        a = 24'h00A000 + 24'($urandom_range(0, 12));
      else
        a = 24'($urandom);
      issue(2'($urandom), $urandom_range(0, 2) == 0, a,
            2'($urandom), $urandom);
    end

`ifdef QSPI_CTRL_RAM_EN
    issue(2'd2, 1'b0, 24'h00A002, 2'd3, 32'd0);
`else
    issue(2'd0, 1'b0, 24'h00A002, 2'd3, 32'd0);
`endif
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (dcyc >= 13) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_data", 32'(hit), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk_reset("abort");
    sbq.delete();
    last_rd = 32'd0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (60) @(negedge clk);

    issue(2'd0, 1'b0, 24'h000010, 2'd3, 32'd0);
    issue(2'd0, 1'b0, 24'($urandom), 2'd1, 32'd0);
    wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    chk("multi_sel", 32'(multi), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
